// File: rtl/prbs4_checker.sv
// rtl/prbs4_checker.sv - self-synchronising PRBS4 (x^4+x^3+1) serial checker
//
// Ports:
//   clock       rising-edge clock shared with the generator
//   reset       asynchronous active-low reset
//   din         serial data bit, sampled when din_valid=1
//   din_valid   qualifies din; low stalls every register
//   clear       synchronous clear of err_count and sat
//   locked      high while the local sequence copy is locked
//   err_pulse   one-cycle pulse per mismatching valid bit while locked
//   err_count   saturating error count since reset/clear
//   sat         sticky flag, err_count reached its maximum
//   stuck_zero  high while synchronising on an all-zero window
module prbs4_checker #(
    parameter int CNT_W     = 8,
    parameter int LOCK_GOOD = 8,
    parameter int LOSS_ERR  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             sat,
    output logic             stuck_zero
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       GOOD_TGT = 4'(LOCK_GOOD);
    localparam logic [2:0]       LOSS_TGT = 3'(LOSS_ERR);

    state_t           state, state_n;
    logic [3:0]       w, w_n;
    logic [1:0]       fill_cnt, fill_n;
    logic [3:0]       good_cnt, good_n;
    logic [2:0]       loss_cnt, loss_n;
    logic [3:0]       run_cnt, run_n;
    logic [CNT_W-1:0] count_n;
    logic             sat_n;
    logic             err_n;
    logic             locked_n;
    logic             stuck_n;
    logic             predict;
    logic             match;

    // w[0] newest, w[3] oldest: b[n] = b[n-3] ^ b[n-4]
    assign predict = w[2] ^ w[3];
    assign match   = (din == predict);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_FILL;
            w          <= 4'b0000;
            fill_cnt   <= 2'd0;
            good_cnt   <= 4'd0;
            loss_cnt   <= 3'd0;
            run_cnt    <= 4'd0;
            err_count  <= '0;
            sat        <= 1'b0;
            err_pulse  <= 1'b0;
            locked     <= 1'b0;
            stuck_zero <= 1'b0;
        end else begin
            state      <= state_n;
            w          <= w_n;
            fill_cnt   <= fill_n;
            good_cnt   <= good_n;
            loss_cnt   <= loss_n;
            run_cnt    <= run_n;
            err_count  <= count_n;
            sat        <= sat_n;
            err_pulse  <= err_n;
            locked     <= locked_n;
            stuck_zero <= stuck_n;
        end
    end

    always_comb begin
        state_n = state;
        w_n     = w;
        fill_n  = fill_cnt;
        good_n  = good_cnt;
        loss_n  = loss_cnt;
        run_n   = run_cnt;
        err_n   = 1'b0;

        if (din_valid) begin
            case (state)
                ST_FILL: begin
                    w_n    = {w[2:0], din};
                    fill_n = fill_cnt + 2'd1;
                    if (fill_cnt == 2'd3) begin
                        state_n = ST_SYNC;
                        good_n  = 4'd0;
                    end
                end
                ST_SYNC: begin
                    w_n = {w[2:0], din};
                    // An all-zero window predicts zeros forever; never trust it.
                    if (w == 4'b0000) begin
                        good_n = 4'd0;
                    end else if (match) begin
                        good_n = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == GOOD_TGT) begin
                            state_n = ST_LOCKED;
                            loss_n  = 3'd0;
                            run_n   = 4'd0;
                        end
                    end else begin
                        good_n = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        err_n  = 1'b1;
                        run_n  = 4'd0;
                        loss_n = loss_cnt + 3'd1;
                        if (loss_cnt + 3'd1 == LOSS_TGT) begin
                            state_n = ST_FILL;
                            fill_n  = 2'd0;
                        end else begin
                            w_n = {w[2:0], predict};
                        end
                    end else begin
                        w_n = {w[2:0], predict};
                        // 16 clean bits in a row forgive earlier errors
                        if (run_cnt == 4'd15) begin
                            run_n  = 4'd0;
                            loss_n = 3'd0;
                        end else begin
                            run_n = run_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state_n = ST_FILL;
                    fill_n  = 2'd0;
                end
            endcase
        end

        count_n = err_count;
        sat_n   = sat;
        if (err_n && (err_count != CNT_MAX)) begin
            count_n = err_count + 1'b1;
        end
        if (count_n == CNT_MAX) begin
            sat_n = 1'b1;
        end
        if (clear) begin
            count_n = '0;
            sat_n   = 1'b0;
        end

        locked_n = (state_n == ST_LOCKED);
        stuck_n  = (state_n == ST_SYNC) && (w_n == 4'b0000);
    end

endmodule

// File: tb/tb_prbs4_checker.sv
// tb/tb_prbs4_checker.sv - self-checking bench for prbs4_checker
module tb_prbs4_checker;

    localparam int LOCK_GOOD = 8;
    localparam int LOSS_ERR  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       clear;

    logic       locked_a, err_pulse_a, sat_a, stuck_zero_a;
    logic [7:0] err_count_a;
    logic       locked_b, err_pulse_b, sat_b, stuck_zero_b;
    logic [3:0] err_count_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    prbs4_checker dut_a (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a),
        .sat(sat_a), .stuck_zero(stuck_zero_a)
    );

    prbs4_checker #(.CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b),
        .sat(sat_b), .stuck_zero(stuck_zero_b)
    );

    // ---------------- reference model ----------------
    // mode 0 = filling, 1 = synchronising, 2 = locked
    int m_mode, m_nfill, m_good, m_loss, m_run;
    int m_hist[$];          // reference bits, oldest first
    int m_cnt8, m_cnt4;
    bit m_sat8, m_sat4, m_pulse;

    function automatic void model_reset();
        m_mode = 0; m_nfill = 0; m_good = 0; m_loss = 0; m_run = 0;
        m_hist.delete();
        m_cnt8 = 0; m_cnt4 = 0; m_sat8 = 0; m_sat4 = 0; m_pulse = 0;
    endfunction

    function automatic void model_push(int b);
        m_hist.push_back(b);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
    endfunction

    function automatic void model_step(bit d, bit v, bit c);
        int pred;
        int zero;
        m_pulse = 0;
        if (v) begin
            case (m_mode)
                0: begin
                    model_push(d);
                    m_nfill++;
                    if (m_nfill == 4) begin m_mode = 1; m_good = 0; end
                end
                1: begin
                    pred = m_hist[0] ^ m_hist[1];
                    zero = (m_hist.sum() == 0);
                    model_push(d);
                    if (zero) m_good = 0;
                    else if (int'(d) == pred) begin
                        m_good++;
                        if (m_good == LOCK_GOOD) begin m_mode = 2; m_loss = 0; m_run = 0; end
                    end else m_good = 0;
                end
                default: begin
                    pred = m_hist[0] ^ m_hist[1];
                    model_push(pred);
                    if (int'(d) != pred) begin
                        m_pulse = 1;
                        if (m_cnt8 < 255) m_cnt8++;
                        if (m_cnt4 < 15) m_cnt4++;
                        if (m_cnt8 == 255) m_sat8 = 1;
                        if (m_cnt4 == 15) m_sat4 = 1;
                        m_loss++;
                        m_run = 0;
                        if (m_loss == LOSS_ERR) begin m_mode = 0; m_nfill = 0; end
                    end else begin
                        m_run++;
                        if (m_run == 16) begin m_run = 0; m_loss = 0; end
                    end
                end
            endcase
        end
        if (c) begin m_cnt8 = 0; m_cnt4 = 0; m_sat8 = 0; m_sat4 = 0; end
    endfunction

    // ---------------- generator (b[n] = b[n-3]^b[n-4], seed 0001) ----------------
    int gq[$];
    function automatic void gen_seed();
        gq = '{0, 0, 0, 1};
    endfunction
    function automatic bit gen_next();
        int o;
        o = gq.pop_front();
        gq.push_back(o ^ gq[0]);
        return bit'(o);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int stuck;
        stuck = (m_mode == 1) && (m_hist.sum() == 0);
        chk("a_locked", locked_a, (m_mode == 2));
        chk("a_pulse", err_pulse_a, m_pulse);
        chk("a_count", err_count_a, m_cnt8);
        chk("a_sat", sat_a, m_sat8);
        chk("a_stuck", stuck_zero_a, stuck);
        chk("b_locked", locked_b, (m_mode == 2));
        chk("b_pulse", err_pulse_b, m_pulse);
        chk("b_count", err_count_b, m_cnt4);
        chk("b_sat", sat_b, m_sat4);
        chk("b_stuck", stuck_zero_b, stuck);
    endtask

    // inputs change just after a falling edge, outputs checked at the next one
    task automatic step(input bit d, input bit v, input bit c);
        din = d; din_valid = v; clear = c;
        @(posedge clock);
        model_step(d, v, c);
        @(negedge clock);
        compare_all();
    endtask

    task automatic clean();
        step(gen_next(), 1'b1, 1'b0);
    endtask

    task automatic bad(input bit c);
        step(~gen_next(), 1'b1, c);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        chk("rst_locked", locked_a, 0);
        chk("rst_count", err_count_a, 0);
        compare_all();
        @(negedge clock);
        reset = 1'b1;
        gen_seed();
    endtask

    typedef struct {
        bit d;
        bit v;
        bit c;
        bit e_locked;
        bit e_pulse;
        int e_cnt;
    } vec_t;

    vec_t        tbl[16];
    logic [14:0] seq_bits;
    bit          seen;

    initial begin
        din = 1'b0; din_valid = 1'b0; clear = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        do_reset();

        // clean lock from reset: locked after the 12th valid bit
        seq_bits = 15'b000100110101111;
        for (int i = 0; i < 16; i++)
            tbl[i] = '{seq_bits[14 - (i % 15)], 1'b1, 1'b0, (i >= 11), 1'b0, 0};
        for (int i = 0; i < 16; i++) begin
            void'(gen_next());
            step(tbl[i].d, tbl[i].v, tbl[i].c);
            chk("tbl_locked", locked_a, tbl[i].e_locked);
            chk("tbl_pulse", err_pulse_a, tbl[i].e_pulse);
            chk("tbl_count", err_count_a, tbl[i].e_cnt);
        end
        for (int i = 0; i < 200; i++) clean();
        chk("clean_count", err_count_a, 0);
        chk("clean_locked", locked_a, 1);

        // isolated errors keep lock
        bad(1'b0);
        chk("err1_pulse", err_pulse_a, 1);
        chk("err1_count", err_count_a, 1);
        chk("err1_locked", locked_a, 1);
        clean();
        chk("err1_pulse_end", err_pulse_a, 0);
        for (int i = 0; i < 15; i++) clean();
        bad(1'b0);
        for (int i = 0; i < 16; i++) clean();
        bad(1'b0);
        chk("iso_locked", locked_a, 1);
        chk("iso_count", err_count_a, 3);

        // three errors close together drop lock, then relock
        for (int i = 0; i < 16; i++) clean();
        bad(1'b0);
        for (int i = 0; i < 3; i++) clean();
        bad(1'b0);
        for (int i = 0; i < 3; i++) clean();
        chk("burst_still_locked", locked_a, 1);
        bad(1'b0);
        chk("burst_drop", locked_a, 0);
        chk("burst_pulse", err_pulse_a, 1);
        chk("burst_count", err_count_a, 6);
        for (int i = 0; i < 11; i++) clean();
        chk("relock_early", locked_a, 0);
        clean();
        chk("relock", locked_a, 1);
        chk("relock_count", err_count_a, 6);

        // valid toggling every cycle
        do_reset();
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) clean();
            else step(1'($urandom), 1'b0, 1'b0);
            if (err_pulse_a) seen = 1;
            if (i == 21) chk("toggle_early", locked_a, 0);
        end
        chk("toggle_locked", locked_a, 1);
        chk("toggle_nopulse", seen, 0);

        // all-zero stream never locks
        do_reset();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 2) chk("stuck_fill", stuck_zero_a, 0);
            if (i == 3) chk("stuck_sync", stuck_zero_a, 1);
            if (locked_a) seen = 1;
        end
        chk("stuck_never_lock", seen, 0);

        // saturation of the 4-bit counter, clear against a same-cycle error
        do_reset();
        for (int i = 0; i < 12; i++) clean();
        chk("sat_locked", locked_b, 1);
        for (int k = 0; k < 20; k++) begin
            bad(1'b0);
            for (int i = 0; i < 19; i++) clean();
        end
        chk("sat_count_b", err_count_b, 15);
        chk("sat_flag_b", sat_b, 1);
        chk("sat_count_a", err_count_a, 20);
        chk("sat_flag_a", sat_a, 0);
        chk("sat_still_locked", locked_b, 1);
        bad(1'b1);
        chk("clr_count_b", err_count_b, 0);
        chk("clr_sat_b", sat_b, 0);
        chk("clr_pulse_b", err_pulse_b, 1);
        chk("clr_locked", locked_b, 1);
        for (int i = 0; i < 3; i++) clean();

        // asynchronous reset mid-lock
        reset = 1'b0;
        #2;
        model_reset();
        chk("arst_locked", locked_a, 0);
        chk("arst_count", err_count_b, 0);
        chk("arst_pulse", err_pulse_a, 0);
        compare_all();
        @(negedge clock);
        reset = 1'b1;
        gen_seed();

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            bit v, c, b;
            v = ($urandom_range(0, 9) < 7);
            c = v && ($urandom_range(0, 49) == 0);
            b = 1'($urandom);
            if (v) begin
                b = gen_next();
                if ($urandom_range(0, 39) == 0) b = ~b;
            end
            step(b, v, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/prbs4_checker.md
# prbs4_checker

Serial PRBS checker directly downstream of the 4-bit LFSR generator (polynomial x^4+x^3+1, recurrence b[n] = b[n-3] XOR b[n-4], period 15). It consumes the generator's serial output bit, self-synchronises a local copy of the sequence, declares lock, then free-runs that copy and counts bit errors. It is the receive-side self-test companion for the generator in link and loopback testing.

## Interface
- CNT_W, 8: error counter width.
- LOCK_GOOD, 8: consecutive matching bits in SYNC required to lock (1..15).
- LOSS_ERR, 3: errors tolerated in LOCKED before lock is dropped (1..7).
- clock  input  1  rising-edge clock shared with the generator.
- reset  input  1  asynchronous, active-low; low forces all state to reset values.
- din  input  1  serial data bit (generator output), sampled at rising edge when din_valid=1.
- din_valid  input  1  qualifies din; low stalls the block, all state holds.
- clear  input  1  synchronous clear of err_count and sat.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatching valid bit in LOCKED.
- err_count  output  CNT_W  saturating count of errors since reset/clear.
- sat  output  1  sticky; err_count has reached 2^CNT_W-1.
- stuck_zero  output  1  high while in SYNC with window == 4'b0000.

## Operation
- Window register w[3:0]: w[0] = newest bit, w[3] = oldest. Predicted bit p = w[2] XOR w[3].
- All actions below occur only on valid cycles; on din_valid=0 nothing changes and err_pulse=0.
- FILL: shift din into w (w <= {w[2:0],din}); 2-bit fill counter; after 4th valid bit go to SYNC, good counter = 0. No comparisons.
- SYNC: compare din with p; shift din into w (self-synchronising). Match and w != 0000: good counter +1; reaching LOCK_GOOD -> LOCKED, loss counter = 0, run counter = 0. Mismatch: good counter = 0, stay in SYNC. w == 0000 (stuck_zero): good counter held at 0 regardless of match, never locks on all-zero stream.
- LOCKED: w <= {w[2:0],p} (free-run; din not loaded). Mismatch: err_pulse, err_count +1 (saturating), loss counter +1, run counter = 0; loss counter reaching LOSS_ERR -> FILL, fill counter = 0, w unchanged. Match: run counter +1; at 16 consecutive matches loss counter = 0, run counter = 0.
- err_count saturates at 2^CNT_W-1, never wraps; sat set on reaching it, held until clear/reset.
- clear: err_count = 0, sat = 0; clear wins over a same-cycle increment (result 0). clear does not affect state, lock or loss counter.
- Lock loss does not clear err_count.

## Timing
- Reset values: state FILL, w=0000, all counters 0, locked=0, err_pulse=0, err_count=0, sat=0, stuck_zero=0.
- All outputs registered. A valid bit sampled at edge k is reflected in locked/err_pulse/err_count after edge k.
- Lock latency from reset release with continuous valid, error-free data: 4 + LOCK_GOOD valid edges (12 by default); locked high after the 12th.
- err_pulse: high exactly for the cycle following the sampling edge of a mismatching bit; low otherwise.
- Lock loss: locked falls after the edge sampling the LOSS_ERR-th counted error; that error is counted and pulsed.
- reset asserted mid-operation: immediate return to reset values, independent of clock.

## Test plan
- Generator seeded 4'b0001, continuous valid, no errors -> locked rises after 12th valid bit, err_count stays 0 for 200 cycles.
- Locked, invert one din bit -> err_pulse high one cycle, err_count=1, locked stays high; 16 clean bits later a further 2 isolated errors do not drop lock.
- Locked, invert 3 bits within 10 cycles -> err_count=3, locked falls after 3rd error, relocks 12 valid bits later, err_count still 3.
- din held 0, valid continuous -> stuck_zero high once in SYNC, locked never asserts over 100 cycles.
- din_valid toggled 1/0 every cycle with clean stream -> lock after 12 valid bits (24 cycles), no err_pulse.
- CNT_W=4, errors spaced 20 bits apart -> err_count stops at 15, sat=1; clear coincident with an error -> err_count=0, sat=0; reset low mid-lock -> all outputs 0 immediately.
